// File: rtl/reg_bank_if.sv
// Register-file access bundle: one write port and two asynchronous read ports.
// The master drives addresses and write data; the slave returns read data.
interface reg_bank_if #(
    parameter int DATA_W = 32
);
    logic              reg_write;
    logic [4:0]        read_reg1;
    logic [4:0]        read_reg2;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    modport master (
        output reg_write, read_reg1, read_reg2, write_reg, write_data,
        input  read_data1, read_data2
    );

    modport slave (
        input  reg_write, read_reg1, read_reg2, write_reg, write_data,
        output read_data1, read_data2
    );
endinterface

// File: rtl/reg_bank.sv
// 32 x DATA_W general-purpose register file for the multicycle MIPS datapath.
// $0 reads as zero; the stack pointer is preloaded on reset.
module reg_bank #(
    parameter int DATA_W  = 32,
    parameter int SP_IDX  = 29,
    parameter int SP_INIT = 227
) (
    input  logic        clk,
    input  logic        reset,
    reg_bank_if.slave   bus
);

    logic [DATA_W-1:0] regs [0:31];

    // Reset beats a write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
        end else if (bus.reg_write && (bus.write_reg != 5'd0)) begin
            regs[bus.write_reg] <= bus.write_data;
        end
    end

    // No write-through bypass: a same-cycle write is visible only after the edge.
    assign bus.read_data1 = (bus.read_reg1 == 5'd0) ? '0 : regs[bus.read_reg1];
    assign bus.read_data2 = (bus.read_reg2 == 5'd0) ? '0 : regs[bus.read_reg2];

endmodule
